// File: rtl/core_pipeline_pkg.sv
// Shared pipeline control types: forwarding selects and hazard FSM states.
package core_pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_WB      = 2'b01,
    FWD_MEM     = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_MEM_ERR
  } hz_state_e;

endpackage

// File: rtl/forwarding_unit.sv
// EX operand bypass selection; MEM result is younger so it wins over WB.
module forwarding_unit
  import core_pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] exRs1_i,
  input  logic [REG_ADDR_W-1:0] exRs2_i,
  input  logic [REG_ADDR_W-1:0] memRd_i,
  input  logic                  memRegWrite_i,
  input  logic [REG_ADDR_W-1:0] wbRd_i,
  input  logic                  wbRegWrite_i,
  output fwd_sel_e              fwdA_o,
  output fwd_sel_e              fwdB_o
);

  logic memLive;
  logic wbLive;

  assign memLive = memRegWrite_i && (memRd_i != '0);
  assign wbLive  = wbRegWrite_i && (wbRd_i != '0);

  always_comb begin
    fwdA_o = FWD_REGFILE;
    fwdB_o = FWD_REGFILE;
    if (memLive && memRd_i == exRs1_i)
      fwdA_o = FWD_MEM;
    else if (wbLive && wbRd_i == exRs1_i)
      fwdA_o = FWD_WB;
    if (memLive && memRd_i == exRs2_i)
      fwdB_o = FWD_MEM;
    else if (wbLive && wbRd_i == exRs2_i)
      fwdB_o = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forward sequencer for the 5-stage pipeline with
// data-memory wait tracking and a stall-cycle counter.
module pipeline_hazard_controller
  import core_pipeline_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int PERF_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic [REG_ADDR_W-1:0] exRs1,
  input  logic [REG_ADDR_W-1:0] exRs2,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  exMemRead,
  input  logic                  exBranchTaken,
  input  logic [REG_ADDR_W-1:0] memRd,
  input  logic                  memRegWrite,
  input  logic                  memReq,
  input  logic                  memReady,
  input  logic [REG_ADDR_W-1:0] wbRd,
  input  logic                  wbRegWrite,
  output logic                  pcStall,
  output logic                  ifIdStall,
  output logic                  ifIdFlush,
  output logic                  idExStall,
  output logic                  idExFlush,
  output logic                  exMemStall,
  output logic                  memWbBubble,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB,
  output logic                  memError,
  output logic [PERF_W-1:0]     stallCycles
);

  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  hz_state_e         state_q, state_d;
  logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
  logic              memErr_q, memErr_d;
  logic [PERF_W-1:0] stall_q, stall_d;

  fwd_sel_e fwdA, fwdB;
  logic     memStall, brFlush, ldUse;

  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
    .exRs1_i       (exRs1),
    .exRs2_i       (exRs2),
    .memRd_i       (memRd),
    .memRegWrite_i (memRegWrite),
    .wbRd_i        (wbRd),
    .wbRegWrite_i  (wbRegWrite),
    .fwdA_o        (fwdA),
    .fwdB_o        (fwdB)
  );

  assign forwardA = reset ? FWD_REGFILE : fwdA;
  assign forwardB = reset ? FWD_REGFILE : fwdB;

  // Mutually exclusive by construction: memory wait > branch > load-use.
  assign memStall = !reset &&
    ((memReq && !memReady) || state_q == ST_MEM_ERR);
  assign brFlush  = !reset && !memStall && exBranchTaken;
  assign ldUse    = !reset && !memStall && !exBranchTaken &&
    exMemRead && (exRd != '0) &&
    (exRd == idRs1 || exRd == idRs2);

  always_comb begin
    pcStall     = 1'b0;
    ifIdStall   = 1'b0;
    ifIdFlush   = 1'b0;
    idExStall   = 1'b0;
    idExFlush   = 1'b0;
    exMemStall  = 1'b0;
    memWbBubble = 1'b0;
    unique case (1'b1)
      memStall: begin
        pcStall     = 1'b1;
        ifIdStall   = 1'b1;
        idExStall   = 1'b1;
        exMemStall  = 1'b1;
        memWbBubble = 1'b1;
      end
      brFlush: begin
        ifIdFlush = 1'b1;
        idExFlush = 1'b1;
      end
      ldUse: begin
        pcStall   = 1'b1;
        ifIdStall = 1'b1;
        idExFlush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    memErr_d  = memErr_q;
    stall_d   = pcStall ? stall_q + PERF_W'(1) : stall_q;
    case (state_q)
      ST_RUN: begin
        if (memReq && !memReady) begin
          state_d   = ST_MEM_WAIT;
          waitCnt_d = CNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (memReady) begin
          state_d   = ST_RUN;
          waitCnt_d = '0;
        end else if (waitCnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d  = ST_MEM_ERR;
          memErr_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
        end
      end
      ST_MEM_ERR: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_RUN;
      waitCnt_q <= '0;
      memErr_q  <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      memErr_q  <= memErr_d;
      stall_q   <= stall_d;
    end
  end

  assign memError    = memErr_q;
  assign stallCycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for the hazard controller (MEM_TIMEOUT=4).
module tb_pipeline_hazard_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  idRs1, idRs2, exRs1, exRs2, exRd;
  logic        exMemRead, exBranchTaken;
  logic [4:0]  memRd, wbRd;
  logic        memRegWrite, memReq, memReady, wbRegWrite;
  logic        pcStall, ifIdStall, ifIdFlush, idExStall;
  logic        idExFlush, exMemStall, memWbBubble, memError;
  logic [1:0]  forwardA, forwardB;
  logic [31:0] stallCycles;

  int errors = 0;
  int checks = 0;

  pipeline_hazard_controller #(
    .REG_ADDR_W (5),
    .MEM_TIMEOUT(4),
    .PERF_W     (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .idRs1        (idRs1),
    .idRs2        (idRs2),
    .exRs1        (exRs1),
    .exRs2        (exRs2),
    .exRd         (exRd),
    .exMemRead    (exMemRead),
    .exBranchTaken(exBranchTaken),
    .memRd        (memRd),
    .memRegWrite  (memRegWrite),
    .memReq       (memReq),
    .memReady     (memReady),
    .wbRd         (wbRd),
    .wbRegWrite   (wbRegWrite),
    .pcStall      (pcStall),
    .ifIdStall    (ifIdStall),
    .ifIdFlush    (ifIdFlush),
    .idExStall    (idExStall),
    .idExFlush    (idExFlush),
    .exMemStall   (exMemStall),
    .memWbBubble  (memWbBubble),
    .forwardA     (forwardA),
    .forwardB     (forwardB),
    .memError     (memError),
    .stallCycles  (stallCycles)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    idRs1 = 0; idRs2 = 0; exRs1 = 0; exRs2 = 0; exRd = 0;
    exMemRead = 0; exBranchTaken = 0;
    memRd = 0; memRegWrite = 0; memReq = 0; memReady = 0;
    wbRd = 0; wbRegWrite = 0;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    tick();
    tick();
    // outputs forced quiet while reset is high
    memReq = 1; exBranchTaken = 1;
    memRd = 3; memRegWrite = 1; exRs1 = 3;
    #1;
    chk("rst_pcStall", 32'(pcStall), 0);
    chk("rst_ifIdFlush", 32'(ifIdFlush), 0);
    chk("rst_bubble", 32'(memWbBubble), 0);
    chk("rst_fwdA", 32'(forwardA), 0);
    tick();
    chk("rst_stallCycles", stallCycles, 0);
    chk("rst_memError", 32'(memError), 0);
    clr();
    reset = 1'b0;

    // 1: load-use
    exMemRead = 1; exRd = 5; idRs1 = 5;
    #1;
    chk("lu_pcStall", 32'(pcStall), 1);
    chk("lu_ifIdStall", 32'(ifIdStall), 1);
    chk("lu_idExFlush", 32'(idExFlush), 1);
    chk("lu_ifIdFlush", 32'(ifIdFlush), 0);
    chk("lu_idExStall", 32'(idExStall), 0);
    tick();
    exMemRead = 0;
    #1;
    chk("lu_release", 32'(pcStall), 0);
    chk("lu_count", stallCycles, 1);

    // 2: x0 never interlocks nor forwards
    exMemRead = 1; exRd = 0; idRs1 = 0;
    memRd = 0; memRegWrite = 1; exRs1 = 0;
    #1;
    chk("x0_noStall", 32'(pcStall), 0);
    chk("x0_fwdA", 32'(forwardA), 0);
    memRd = 3; exRs1 = 3;
    #1;
    chk("memFwdA", 32'(forwardA), 2);
    tick();
    clr();

    // 3: MEM beats WB, then WB alone
    memRd = 7; memRegWrite = 1; wbRd = 7; wbRegWrite = 1; exRs2 = 7;
    #1;
    chk("dbl_fwdB", 32'(forwardB), 2);
    memRegWrite = 0;
    #1;
    chk("wb_fwdB", 32'(forwardB), 1);
    wbRegWrite = 0;
    #1;
    chk("none_fwdB", 32'(forwardB), 0);
    clr();

    // 4: 3-cycle memory wait with a held taken branch
    memReq = 1; memReady = 0; exBranchTaken = 1;
    #1;
    chk("mw1_pcStall", 32'(pcStall), 1);
    chk("mw1_exMemStall", 32'(exMemStall), 1);
    chk("mw1_bubble", 32'(memWbBubble), 1);
    chk("mw1_noFlush", 32'(ifIdFlush), 0);
    tick();
    chk("mw2_idExStall", 32'(idExStall), 1);
    chk("mw2_noFlush", 32'(idExFlush), 0);
    tick();
    chk("mw3_pcStall", 32'(pcStall), 1);
    tick();
    memReady = 1;
    #1;
    chk("mw_rel_pcStall", 32'(pcStall), 0);
    chk("mw_rel_ifIdFlush", 32'(ifIdFlush), 1);
    chk("mw_rel_idExFlush", 32'(idExFlush), 1);
    tick();
    clr();
    #1;
    chk("mw_count", stallCycles, 4);
    chk("mw_noErr", 32'(memError), 0);
    chk("mw_run", 32'(pcStall), 0);

    // 5: timeout after 4 stall cycles
    memReq = 1; memReady = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_noErrYet", 32'(memError), 0);
      tick();
    end
    #1;
    chk("to_memError", 32'(memError), 1);
    chk("to_count", stallCycles, 8);
    memReady = 1; exBranchTaken = 1;
    #1;
    chk("err_pcStall", 32'(pcStall), 1);
    chk("err_bubble", 32'(memWbBubble), 1);
    chk("err_noFlush", 32'(ifIdFlush), 0);
    tick();
    chk("err_count", stallCycles, 9);
    chk("err_sticky", 32'(memError), 1);
    reset = 1;
    #1;
    chk("err_rst_pcStall", 32'(pcStall), 0);
    tick();
    chk("err_rst_memError", 32'(memError), 0);
    chk("err_rst_count", stallCycles, 0);
    reset = 0;
    clr();

    // 6: branch beats load-use
    exBranchTaken = 1; exMemRead = 1; exRd = 5; idRs1 = 5;
    #1;
    chk("bl_ifIdFlush", 32'(ifIdFlush), 1);
    chk("bl_idExFlush", 32'(idExFlush), 1);
    chk("bl_pcStall", 32'(pcStall), 0);
    chk("bl_ifIdStall", 32'(ifIdStall), 0);
    clr();
    // reset in the middle of a memory wait
    memReq = 1; memReady = 0;
    tick();
    tick();
    chk("rw_count", stallCycles, 2);
    reset = 1;
    #1;
    chk("rw_rst_pcStall", 32'(pcStall), 0);
    chk("rw_rst_bubble", 32'(memWbBubble), 0);
    tick();
    reset = 0;
    memReq = 0;
    #1;
    chk("rw_pcStall", 32'(pcStall), 0);
    chk("rw_count0", stallCycles, 0);
    chk("rw_memError", 32'(memError), 0);
    // a fresh 3-cycle wait must not time out
    memReq = 1;
    tick();
    tick();
    tick();
    chk("rw_fresh_noErr", 32'(memError), 0);
    chk("rw_fresh_count", stallCycles, 3);
    clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
